// File: rtl/mask_filter.sv
// Bitwise mask filter: combinational out/dropped paths plus clocked drop statistics.
// Define MASK_FILTER_POPCNT_EN to add the combinational popcnt output (adder tree).
module mask_filter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WIDTH-1:0]      in,
    input  logic [WIDTH-1:0]      mask,
    input  logic                  clr,
    output logic [WIDTH-1:0]      out,
    output logic                  out_zero,
    output logic [WIDTH-1:0]      dropped,
    output logic [WIDTH-1:0]      dropped_sticky,
    output logic [CNT_W-1:0]      drop_count
`ifdef MASK_FILTER_POPCNT_EN
    ,
    output logic [$clog2(WIDTH):0] popcnt
`endif
);

    logic [WIDTH-1:0] sticky_q, sticky_d;
    logic [CNT_W-1:0] count_q, count_d;

    assign out      = in & mask;
    assign dropped  = in & ~mask;
    assign out_zero = ~|out;

    // Clear wins over accumulation; the counter holds at all-ones instead of wrapping.
    always_comb begin
        sticky_d = sticky_q;
        count_d  = count_q;
        if (clr) begin
            sticky_d = '0;
            count_d  = '0;
        end else begin
            sticky_d = sticky_q | dropped;
            if ((|dropped) && (count_q != {CNT_W{1'b1}})) begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= '0;
            count_q  <= '0;
        end else begin
            sticky_q <= sticky_d;
            count_q  <= count_d;
        end
    end

    assign dropped_sticky = sticky_q;
    assign drop_count     = count_q;

`ifdef MASK_FILTER_POPCNT_EN
    localparam int PW = $clog2(WIDTH) + 1;
    localparam int NL = 1 << $clog2(WIDTH);

    // Heap-ordered binary tree: leaves at NL..2*NL-1, root at index 1.
    logic [PW-1:0] node [1:2*NL-1];

    for (genvar li = 0; li < NL; li++) begin : g_leaf
        if (li < WIDTH) begin : g_bit
            assign node[NL+li] = {{(PW-1){1'b0}}, out[li]};
        end else begin : g_pad
            assign node[NL+li] = '0;
        end
    end

    for (genvar ni = 1; ni < NL; ni++) begin : g_sum
        assign node[ni] = node[2*ni] + node[2*ni+1];
    end

    assign popcnt = node[1];
`endif

endmodule

// File: tb/tb_mask_filter.sv
// Scoreboard bench for mask_filter: stimulus pushes hand-computed expectations, a monitor checks them.
module tb_mask_filter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] d_in = '0;
    logic [31:0] d_mask = '0;
    logic        d_clr = 1'b0;
    logic [31:0] d_out, d_drop, d_st;
    logic        d_zero;
    logic [15:0] d_cnt;

    logic        s_rst_n = 1'b0;
    logic [7:0]  s_in = 8'hff;
    logic [7:0]  s_mask = 8'h00;
    logic        s_clr = 1'b0;
    logic [7:0]  s_out, s_drop, s_st;
    logic        s_zero;
    logic [3:0]  s_cnt;

`ifdef MASK_FILTER_POPCNT_EN
    logic [5:0]  d_pc;
    logic [3:0]  s_pc;
`endif

    always #5 clk = ~clk;

    mask_filter #(.WIDTH(32), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in(d_in), .mask(d_mask), .clr(d_clr),
        .out(d_out), .out_zero(d_zero), .dropped(d_drop),
        .dropped_sticky(d_st), .drop_count(d_cnt)
`ifdef MASK_FILTER_POPCNT_EN
        , .popcnt(d_pc)
`endif
    );

    // Narrow counter instance so saturation is reachable in a few cycles.
    mask_filter #(.WIDTH(8), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(s_rst_n), .in(s_in), .mask(s_mask), .clr(s_clr),
        .out(s_out), .out_zero(s_zero), .dropped(s_drop),
        .dropped_sticky(s_st), .drop_count(s_cnt)
`ifdef MASK_FILTER_POPCNT_EN
        , .popcnt(s_pc)
`endif
    );

    typedef struct {
        string       name;
        bit          sat;
        logic [31:0] eout;
        logic [31:0] edrop;
        logic        ezero;
        logic [31:0] est;
        logic [15:0] ecnt;
        logic [5:0]  epc;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_miss = 0;

    task automatic cmp(input string n, input string f, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s.%s: got %h expected %h", n, f, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            if (!e.sat) begin
                cmp(e.name, "out", d_out, e.eout);
                cmp(e.name, "dropped", d_drop, e.edrop);
                cmp(e.name, "out_zero", {31'b0, d_zero}, {31'b0, e.ezero});
                cmp(e.name, "sticky", d_st, e.est);
                cmp(e.name, "count", {16'b0, d_cnt}, {16'b0, e.ecnt});
`ifdef MASK_FILTER_POPCNT_EN
                cmp(e.name, "popcnt", {26'b0, d_pc}, {26'b0, e.epc});
`endif
            end else begin
                cmp(e.name, "out", {24'b0, s_out}, e.eout);
                cmp(e.name, "dropped", {24'b0, s_drop}, e.edrop);
                cmp(e.name, "out_zero", {31'b0, s_zero}, {31'b0, e.ezero});
                cmp(e.name, "sticky", {24'b0, s_st}, e.est);
                cmp(e.name, "count", {28'b0, s_cnt}, {16'b0, e.ecnt});
`ifdef MASK_FILTER_POPCNT_EN
                cmp(e.name, "popcnt", {28'b0, s_pc}, {26'b0, e.epc});
`endif
            end
        end
    end

    // Inputs change just after a rising edge; the monitor checks at the following falling edge,
    // so stats reflect the edge that sampled the previous vector.
    task automatic apply(input string n, input logic r, input logic [31:0] i, input logic [31:0] m,
                         input logic c, input logic [31:0] eo, input logic [31:0] ed, input logic ez,
                         input logic [31:0] es, input logic [15:0] ec, input logic [5:0] ep);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n  = r;
        d_in   = i;
        d_mask = m;
        d_clr  = c;
        e.name = n; e.sat = 1'b0; e.eout = eo; e.edrop = ed; e.ezero = ez;
        e.est = es; e.ecnt = ec; e.epc = ep;
        q.push_back(e);
    endtask

    task automatic apply_sat(input string n, input logic c, input logic [15:0] ec, input logic [31:0] es);
        exp_t e;
        @(posedge clk);
        #1;
        s_rst_n = 1'b1;
        s_clr   = c;
        e.name = n; e.sat = 1'b1; e.eout = 32'h0; e.edrop = 32'hff; e.ezero = 1'b1;
        e.est = es; e.ecnt = ec; e.epc = 6'd0;
        q.push_back(e);
    endtask

    initial begin
        apply("reset",    0, 32'h00000000, 32'h00000000, 0, 32'h00000000, 32'h00000000, 1, 32'h0, 16'd0, 6'd0);
        apply("t1_rst",   0, 32'hffffffff, 32'hf0f0f0f0, 0, 32'hf0f0f0f0, 32'h0f0f0f0f, 0, 32'h0, 16'd0, 6'd16);
        apply("t2_rst",   0, 32'h12312312, 32'h50f37431, 0, 32'h10312010, 32'h02000302, 0, 32'h0, 16'd0, 6'd6);
        apply("release",  1, 32'h12312312, 32'h50f37431, 0, 32'h10312010, 32'h02000302, 0, 32'h0, 16'd0, 6'd6);
        apply("clk1",     1, 32'h12312312, 32'h50f37431, 0, 32'h10312010, 32'h02000302, 0, 32'h02000302, 16'd1, 6'd6);
        apply("clk2",     1, 32'h12312312, 32'hffffffff, 0, 32'h12312312, 32'h00000000, 0, 32'h02000302, 16'd2, 6'd10);
        for (int k = 0; k < 4; k++) begin
            apply($sformatf("hold%0d", k), 1, 32'h12312312, 32'hffffffff, 0, 32'h12312312, 32'h0, 0,
                  32'h02000302, 16'd2, 6'd10);
        end
        apply("clr_set",  1, 32'hffffffff, 32'h00000000, 1, 32'h00000000, 32'hffffffff, 1, 32'h02000302, 16'd2, 6'd0);
        apply("clr_done", 1, 32'h00000000, 32'h00000000, 0, 32'h00000000, 32'h00000000, 1, 32'h0, 16'd0, 6'd0);
        apply("acc_a",    1, 32'h0000000f, 32'h00000000, 0, 32'h00000000, 32'h0000000f, 1, 32'h0, 16'd0, 6'd0);
        apply("acc_b",    1, 32'h000000f0, 32'h00000000, 0, 32'h00000000, 32'h000000f0, 1, 32'h0000000f, 16'd1, 6'd0);
        apply("acc_c",    1, 32'h00000000, 32'h00000000, 0, 32'h00000000, 32'h00000000, 1, 32'h000000ff, 16'd2, 6'd0);
        apply("a5_mask",  1, 32'ha5a5a5a5, 32'h0f0f0f0f, 0, 32'h05050505, 32'ha0a0a0a0, 0, 32'h000000ff, 16'd2, 6'd8);
        apply("async_rst",0, 32'h00000000, 32'h00000000, 0, 32'h00000000, 32'h00000000, 1, 32'h0, 16'd0, 6'd0);

        for (int k = 0; k < 20; k++) begin
            apply_sat($sformatf("sat%0d", k), 0, (k > 15) ? 16'd15 : k[15:0], (k == 0) ? 32'h0 : 32'hff);
        end
        apply_sat("sat_clr",  1, 16'd15, 32'hff);
        apply_sat("sat_clrd", 0, 16'd0, 32'h0);

        for (int k = 0; k < 5 && q.size() > 0; k++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_miss++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
